i2c_reg_sequencer: RTL and testbench
====================================

Name: i2c_reg_sequencer

Overview:
Transaction sequencer in front of the byte-level I2C master (top_i2c command interface: start/stop/write/read/data_in/ack_in, done/busy/ack_err/data_out).
- Turns one register-access request into the full command sequence:
  - Write: START+dev-addr(W), reg-addr, N data bytes, STOP.
  - Read: START+dev-addr(W), reg-addr, repeated-START+dev-addr(R), N read bytes with ACK/NACK, STOP.
- Game logic (sensor/EEPROM access) uses this block and never drives the master directly.

Parameters:
MAX_LEN, 4, maximum bytes per transaction (1..16).
TIMEOUT_CYC, 200000, clk cycles allowed per master command before abort.
LEN_W, 3, width of len field; must hold 1..MAX_LEN, with 0 treated as 1.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
req  in  1  start transaction; sampled only in IDLE
rw  in  1  0=write, 1=read
dev_addr  in  7  7-bit slave address
reg_addr  in  8  register/sub-address byte
len  in  LEN_W  byte count
wr_data  in  8*MAX_LEN  write bytes; byte 0 is in bits [7:0]
rd_data  out  8*MAX_LEN  read bytes; byte 0 is in bits [7:0]
busy  out  1  transaction in progress
done  out  1  one-cycle pulse at end of transaction
err  out  1  valid with done: 1 = NACK or timeout
m_start, m_stop, m_write, m_read  out  1 each  master commands
m_data_in  out  8  byte to master
m_ack_in  out  1  ACK(0)/NACK(1) the master sends after a read byte
m_done, m_busy, m_ack_err  in  1 each  master status
m_data_out  in  8  byte read by master

Behaviour:
- Reset values:
  - All outputs 0, including rd_data.
  - State IDLE; counters 0.
- Request capture:
  - In IDLE, req=1 latches rw, dev_addr, reg_addr, len (0→1) and wr_data.
  - busy=1 from the next cycle. req is ignored while busy.
- States and transitions:
  - IDLE → S_ADDR:
    - Drive m_start=m_write=1, m_data_in={dev_addr,1'b0}.
    - Hold until m_busy=1 is sampled, then drop both commands.
    - → W_ADDR.
  - W_ADDR: wait for m_done.
    - m_ack_err=1 → ABORT.
    - Otherwise → S_REG.
  - S_REG: one-cycle m_write with m_data_in=reg_addr → W_REG.
  - W_REG: on m_done, NACK → ABORT.
    - rw=0 → S_WR.
    - rw=1 → S_RS.
  - S_WR: one-cycle m_write with m_data_in=wr_data[idx] → W_WR.
  - W_WR: on m_done, NACK → ABORT.
    - idx==len-1 → S_STOP.
    - Otherwise idx++ → S_WR.
  - S_RS (repeated start):
    - One-cycle m_start=m_write=1, m_data_in={dev_addr,1'b1}.
    - → W_RS, which waits for m_done; NACK → ABORT.
  - S_RD: one-cycle m_read.
    - m_ack_in=1 only when idx==len-1, else 0.
    - m_ack_in is held stable until the matching m_done.
  - W_RD: on m_done, store m_data_out into rd_data[idx].
    - Last byte → S_STOP.
    - Otherwise idx++ → S_RD.
  - S_STOP:
    - Assert m_stop until m_busy=0 is sampled.
    - Then → FIN with done=1 for one cycle, err=sticky error flag.
    - → IDLE with busy=0.
  - ABORT: set error flag → S_STOP.
- Timeout:
  - Counter is cleared on every command issue.
  - It increments in every W_* state and in S_STOP.
  - Reaching TIMEOUT_CYC in a W_* state → ABORT.
  - In S_STOP → FIN with err=1 and m_stop dropped. The bus may be hung; this is not retried.
- Command outputs are registered.
  - Only one of m_write/m_read is ever set in a cycle.
  - m_stop is never set together with m_start.
- Precedence: m_done and a timeout in the same cycle → m_done wins.
- rd_data is not cleared between transactions. Bytes not read in the current transaction keep their old values.
- Reset mid-transaction: immediate return to IDLE with all commands deasserted. The master is reset by the same reset.

Decomposition:
- Shared package i2c_pkg:
  - State encoding constants.
  - ACK=0 / NACK=1.
  - RW_BIT position.
- Sub-module i2c_cmd_timer: timeout counter with clear/enable/expired.

Test Plan:
- Write, dev 0x50, reg 0x10, len=2, data {0x55,0xAA}:
  - master sees 0xA0, 0x10, 0xAA→ wait, order byte0 first: 0x55 then 0xAA, then STOP.
  - done=1, err=0.
- Read, dev 0x50, reg 0x20, len=3, slave returns 0x11, 0x22, 0x33:
  - rd_data[23:0]=0x332211.
  - m_ack_in is 0, 0, 1.
  - RS byte is 0xA1.
- Slave NACKs the address byte:
  - S_REG is never entered; m_stop is issued.
  - done with err=1; busy falls after m_busy=0.
- Slave never completes a byte (m_done stuck 0), TIMEOUT_CYC=100:
  - ABORT after 100 cycles, then STOP, done with err=1.
- req pulsed while busy:
  - Ignored; the captured fields are unchanged.
  - A req on the cycle after done starts a new transaction.
- reset asserted in W_RD:
  - All outputs 0 asynchronously; state is IDLE.
  - The next req runs normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and I2C bit constants for the register sequencer
package i2c_pkg;
    typedef enum logic [3:0] {
        IDLE, S_ADDR, W_ADDR, S_REG, W_REG, S_WR, W_WR, S_RS, W_RS, S_RD, W_RD, S_STOP, ABORT, FIN
    } state_t;
    localparam logic ACK = 1'b0;
    localparam logic NACK = 1'b1;
    localparam int RW_BIT = 0;
    function automatic logic [7:0] addr_byte(input logic [6:0] dev, input logic rd);
        addr_byte = {dev, 1'b0};
        addr_byte[RW_BIT] = rd;
    endfunction
endpackage

// File: rtl/i2c_cmd_timer.sv
// i2c_cmd_timer: per-command watchdog; counts while enabled and saturates at TIMEOUT_CYC
module i2c_cmd_timer #(
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] cnt;
    assign expired = cnt == TW'(TIMEOUT_CYC);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/i2c_reg_sequencer.sv
// i2c_reg_sequencer: expands one register read/write request into the byte-level
// START/addr/reg/data/repeated-START/STOP command sequence for the I2C master.
module i2c_reg_sequencer
    import i2c_pkg::*;
#(
    parameter int MAX_LEN = 4,
    parameter int TIMEOUT_CYC = 200000,
    parameter int LEN_W = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req,
    input  logic                 rw,
    input  logic [6:0]           dev_addr,
    input  logic [7:0]           reg_addr,
    input  logic [LEN_W-1:0]     len,
    input  logic [8*MAX_LEN-1:0] wr_data,
    output logic [8*MAX_LEN-1:0] rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 m_start,
    output logic                 m_stop,
    output logic                 m_write,
    output logic                 m_read,
    output logic [7:0]           m_data_in,
    output logic                 m_ack_in,
    input  logic                 m_done,
    input  logic                 m_busy,
    input  logic                 m_ack_err,
    input  logic [7:0]           m_data_out
);
    localparam int IW = MAX_LEN > 1 ? $clog2(MAX_LEN) : 1;
    state_t state;
    logic rw_q, err_f, tclr, expired, wait_st;
    logic [6:0] dev_q;
    logic [7:0] reg_q;
    logic [IW-1:0] idx, last;
    logic [MAX_LEN-1:0][7:0] wr_q, rd_q;
    logic [LEN_W-1:0] len_c;
    assign len_c = len == '0 ? LEN_W'(1) : (int'(len) > MAX_LEN ? LEN_W'(MAX_LEN) : len);
    assign rd_data = rd_q;
    assign wait_st = state inside {W_ADDR, W_REG, W_WR, W_RS, W_RD, S_STOP};
    // the count restarts whenever a command is issued, including STOP entered straight from a wait state
    i2c_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk, .reset, .clr(tclr || !wait_st), .en(wait_st), .expired
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            {busy, done, err, m_start, m_stop, m_write, m_read, m_ack_in} <= '0;
            m_data_in <= '0;
            rd_q <= '0;
            wr_q <= '0;
            {rw_q, err_f, tclr} <= '0;
            dev_q <= '0;
            reg_q <= '0;
            idx <= '0;
            last <= '0;
        end else begin
            {m_start, m_write, m_read, done, tclr} <= '0;
            case (state)
                IDLE: if (req) begin
                    rw_q <= rw;
                    dev_q <= dev_addr;
                    reg_q <= reg_addr;
                    wr_q <= wr_data;
                    last <= IW'(len_c - 1'b1);
                    idx <= '0;
                    err_f <= 1'b0;
                    busy <= 1'b1;
                    {m_start, m_write} <= 2'b11;
                    m_data_in <= addr_byte(dev_addr, 1'b0);
                    state <= S_ADDR;
                end
                S_ADDR: if (m_busy) state <= W_ADDR; else {m_start, m_write} <= 2'b11;
                W_ADDR: if (m_done) state <= m_ack_err ? ABORT : S_REG; else if (expired) state <= ABORT;
                S_REG: begin
                    m_write <= 1'b1;
                    m_data_in <= reg_q;
                    state <= W_REG;
                end
                W_REG: if (m_done) state <= m_ack_err ? ABORT : rw_q ? S_RS : S_WR; else if (expired) state <= ABORT;
                S_WR: begin
                    m_write <= 1'b1;
                    m_data_in <= wr_q[idx];
                    state <= W_WR;
                end
                W_WR: if (m_done) begin
                    if (m_ack_err) state <= ABORT;
                    else if (idx == last) {state, m_stop, tclr} <= {S_STOP, 2'b11};
                    else {idx, state} <= {idx + 1'b1, S_WR};
                end else if (expired) state <= ABORT;
                S_RS: begin
                    {m_start, m_write} <= 2'b11;
                    m_data_in <= addr_byte(dev_q, 1'b1);
                    state <= W_RS;
                end
                W_RS: if (m_done) state <= m_ack_err ? ABORT : S_RD; else if (expired) state <= ABORT;
                S_RD: begin
                    m_read <= 1'b1;
                    m_ack_in <= idx == last ? NACK : ACK;
                    state <= W_RD;
                end
                W_RD: if (m_done) begin
                    rd_q[idx] <= m_data_out;
                    m_ack_in <= ACK;
                    if (idx == last) {state, m_stop, tclr} <= {S_STOP, 2'b11};
                    else {idx, state} <= {idx + 1'b1, S_RD};
                end else if (expired) {state, m_ack_in} <= {ABORT, ACK};
                // a stop that never completes still ends the transaction, flagged as an error
                S_STOP: if (!m_busy || expired) begin
                    m_stop <= 1'b0;
                    done <= 1'b1;
                    err <= err_f || m_busy;
                    state <= FIN;
                end
                ABORT: begin
                    err_f <= 1'b1;
                    m_stop <= 1'b1;
                    state <= S_STOP;
                end
                FIN: begin
                    err <= 1'b0;
                    busy <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// tb_i2c_reg_sequencer: drives register transactions against a behavioural byte-master/slave
// and compares bus traffic, status and read data with expectations built from the request.
module tb_i2c_reg_sequencer;
    localparam int MAX_LEN = 4, LEN_W = 3;
    logic clk = 0, reset = 1, req = 0, rw = 0;
    logic [6:0] dev_addr = 0;
    logic [7:0] reg_addr = 0;
    logic [LEN_W-1:0] len = 0;
    logic [31:0] wr_data = 0, rd_data;
    logic busy, done, err, m_start, m_stop, m_write, m_read, m_ack_in;
    logic [7:0] m_data_in, m_data_out = 0;
    logic m_done = 0, m_busy = 0, m_ack_err = 0;
    int checks = 0, errors = 0;
    always #5 clk = ~clk;

    i2c_reg_sequencer #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(100), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .req(req), .rw(rw), .dev_addr(dev_addr), .reg_addr(reg_addr),
        .len(len), .wr_data(wr_data), .rd_data(rd_data), .busy(busy), .done(done), .err(err),
        .m_start(m_start), .m_stop(m_stop), .m_write(m_write), .m_read(m_read),
        .m_data_in(m_data_in), .m_ack_in(m_ack_in), .m_done(m_done), .m_busy(m_busy),
        .m_ack_err(m_ack_err), .m_data_out(m_data_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // byte-level master + slave: logs every byte on the bus, answers after a random latency
    int op_lat = 0, stop_lat = 0, nack_at = -1, stops = 0;
    bit op_rd = 0, hang = 0, ack_moved = 0, bad_cmd = 0;
    logic held_ack = 0;
    logic [7:0] wlog[$], sdata[$];
    logic alog[$];
    always @(negedge clk) begin
        if (reset) begin
            m_done = 0; m_busy = 0; m_ack_err = 0; m_data_out = 0; op_lat = 0; stop_lat = 0;
        end else begin
            m_done = 0;
            m_ack_err = 0;
            if ((m_write && m_read) || (m_stop && m_start)) bad_cmd = 1;
            if (stop_lat > 0) begin
                stop_lat--;
                if (stop_lat == 0) m_busy = 0;
            end else if (m_stop && m_busy) begin
                stops++;
                op_lat = 0;
                stop_lat = $urandom_range(1, 4);
            end else if (op_lat > 0) begin
                if (op_rd && m_ack_in !== held_ack) ack_moved = 1;
                if (!hang) op_lat--;
                if (op_lat == 0) begin
                    m_done = 1;
                    if (op_rd) begin
                        if (sdata.size() > 0) m_data_out = sdata.pop_front();
                        else m_data_out = 8'hEE;
                        alog.push_back(m_ack_in);
                    end else m_ack_err = (wlog.size() - 1 == nack_at);
                end
            end else if (m_read) begin
                op_rd = 1;
                held_ack = m_ack_in;
                op_lat = $urandom_range(1, 5);
            end else if (m_write) begin
                if (m_start) m_busy = 1;
                wlog.push_back(m_data_in);
                op_rd = 0;
                op_lat = $urandom_range(1, 5);
            end
        end
    end

    logic [31:0] exp_rd = 0;

    task automatic run(input bit r, input logic [6:0] d, input logic [7:0] ra, input logic [LEN_W-1:0] l,
                       input logic [31:0] wd, input logic [31:0] sd, input int nk, input bit hg, input bit poke);
        int n, cyc;
        logic [7:0] eb[$];
        logic ea[$];
        bit ee;
        n = l == 0 ? 1 : (int'(l) > MAX_LEN ? MAX_LEN : int'(l));
        eb.push_back({d, 1'b0});
        eb.push_back(ra);
        if (r) eb.push_back({d, 1'b1});
        else for (int i = 0; i < n; i++) eb.push_back(wd[8*i +: 8]);
        ee = hg || nk >= 0;
        if (hg) eb = eb[0:0];
        else if (nk >= 0) eb = eb[0:nk];
        sdata.delete();
        if (r && !ee) for (int i = 0; i < n; i++) begin
            sdata.push_back(sd[8*i +: 8]);
            exp_rd[8*i +: 8] = sd[8*i +: 8];
            ea.push_back(i == n - 1);
        end
        wlog.delete(); alog.delete();
        stops = 0; nack_at = nk; hang = hg; ack_moved = 0; bad_cmd = 0;
        rw = r; dev_addr = d; reg_addr = ra; len = l; wr_data = wd; req = 1;
        @(posedge clk); #1 req = 0;
        check("busy_rise", busy, 1);
        cyc = 0;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 rw = ~r; dev_addr = ~d; reg_addr = ~ra; len = 3'd1; wr_data = ~wd; req = 1;
            @(posedge clk); #1 req = 0;
            cyc = 4;
        end
        while (!done && cyc < 2000) begin
            @(posedge clk); #1 cyc++;
        end
        check("done_seen", done, 1);
        check("err", err, ee);
        if (hg) check("timeout_window", cyc >= 100 && cyc <= 115, 1);
        check("m_busy_idle", m_busy, 0);
        check("nbytes", wlog.size(), eb.size());
        foreach (eb[i]) if (i < wlog.size()) check($sformatf("byte%0d", i), wlog[i], eb[i]);
        check("nreads", alog.size(), ea.size());
        foreach (ea[i]) if (i < alog.size()) check($sformatf("ack%0d", i), alog[i], ea[i]);
        check("ack_stable", ack_moved, 0);
        check("cmd_exclusive", bad_cmd, 0);
        check("stops", stops, 1);
        check("rd_data", rd_data, exp_rd);
        @(posedge clk); #1;
        check("done_pulse", done, 0);
        check("busy_fall", busy, 0);
    endtask

    initial begin
        int r, l, nw, nk, cyc;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", {busy, done, err, m_start, m_stop, m_write, m_read, m_ack_in}, 0);
        check("rst_data_in", m_data_in, 0);
        check("rst_rd_data", rd_data, 0);
        reset = 0;
        @(posedge clk); #1;
        run(0, 7'h50, 8'h10, 3'd2, 32'h0000AA55, 0, -1, 0, 0);
        run(1, 7'h50, 8'h20, 3'd3, 0, 32'h00332211, -1, 0, 0);
        check("rd_low24", rd_data[23:0], 24'h332211);
        run(0, 7'h50, 8'h10, 3'd2, 32'h00001234, 0, 0, 0, 0);
        run(1, 7'h3C, 8'h44, 3'd2, 0, 32'h0000BEEF, 2, 0, 0);
        run(1, 7'h2A, 8'h05, 3'd1, 0, 32'h000000C3, -1, 1, 0);
        run(0, 7'h11, 8'h22, 3'd4, 32'hDEADBEEF, 0, -1, 0, 1);
        run(1, 7'h12, 8'h34, 3'd4, 0, 32'hCAFEF00D, -1, 0, 1);
        run(0, 7'h7F, 8'hFF, 3'd0, 32'h000000A5, 0, -1, 0, 0);
        run(1, 7'h01, 8'h00, 3'd0, 0, 32'h0000005A, -1, 0, 0);
        // reset while waiting on a read byte
        sdata.delete();
        sdata.push_back(8'h01); sdata.push_back(8'h02); sdata.push_back(8'h03);
        hang = 0; nack_at = -1;
        rw = 1; dev_addr = 7'h33; reg_addr = 8'h01; len = 3'd3; req = 1;
        @(posedge clk); #1 req = 0;
        cyc = 0;
        while (!m_read && cyc < 200) begin
            @(posedge clk); #1 cyc++;
        end
        check("reached_read", m_read, 1);
        #2 reset = 1;
        #1;
        check("mid_rst_flags", {busy, done, err, m_start, m_stop, m_write, m_read, m_ack_in}, 0);
        check("mid_rst_data_in", m_data_in, 0);
        check("mid_rst_rd_data", rd_data, 0);
        @(posedge clk); #1 reset = 0;
        exp_rd = 0;
        run(1, 7'h33, 8'h01, 3'd3, 0, 32'h00778899, -1, 0, 0);
        for (int t = 0; t < 25; t++) begin
            r = $urandom_range(0, 1);
            l = $urandom_range(0, 4);
            nw = r ? 3 : (l == 0 ? 1 : l) + 2;
            nk = $urandom_range(0, 3) == 0 ? $urandom_range(0, nw - 1) : -1;
            run(r[0], 7'($urandom), 8'($urandom), LEN_W'(l), $urandom, $urandom, nk, 0,
                nk < 0 && $urandom_range(0, 4) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
